// File: rtl/ysyx_24070016_idu_immenc_if.sv
// Command/beat bundle for the RV32I instruction encoder.
// The encoder takes the slave side; whoever drives commands takes the master side.
interface ysyx_24070016_idu_immenc_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_fmt;
  logic        in_li;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_last;
  logic        out_err;

  modport slave (
    input  in_valid, in_fmt, in_li, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_inst, out_last, out_err
  );

  modport master (
    output in_valid, in_fmt, in_li, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_inst, out_last, out_err
  );
endinterface

// File: rtl/ysyx_24070016_idu_immenc.sv
// Packs a field-level instruction description into an RV32I word; inverse of the IDU
// immediate generator. Load-immediate commands may expand into a LUI/ADDI pair.
module ysyx_24070016_idu_immenc (
  input logic                          clk,
  input logic                          rst_n,
  ysyx_24070016_idu_immenc_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_e;

  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_ADDI = 7'b0010011;

  state_e      state, state_nxt;
  logic [31:0] inst_q, second_q;
  logic        last_q, err_q;

  logic [31:0] enc_first, enc_second;
  logic        enc_last, enc_err;
  logic [11:0] li_lo;
  logic [19:0] li_hi;
  logic        imm_i_ok, imm_b_ok, imm_j_ok, imm_u_ok;
  logic        accept, consume;

  assign accept  = bus.in_valid & bus.in_ready;
  assign consume = bus.out_valid & bus.out_ready;

  // Immediate range checks; a failure flags out_err but the truncated word still goes out.
  assign imm_i_ok = (&bus.in_imm[31:11]) | ~(|bus.in_imm[31:11]);
  assign imm_b_ok = ((&bus.in_imm[31:12]) | ~(|bus.in_imm[31:12])) & ~bus.in_imm[0];
  assign imm_j_ok = ((&bus.in_imm[31:20]) | ~(|bus.in_imm[31:20])) & ~bus.in_imm[0];
  assign imm_u_ok = ~(|bus.in_imm[11:0]);

  // ADDI sign-extends its 12-bit operand, so the upper part is rounded up when lo is negative.
  assign li_lo = bus.in_imm[11:0];
  assign li_hi = bus.in_imm[31:12] + {19'd0, bus.in_imm[11]};

  // NOTE: every output of a combinational block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    enc_first  = '0;
    enc_second = '0;
    enc_last   = 1'b1;
    enc_err    = 1'b0;
    if (bus.in_li) begin
      if (li_hi == 20'd0) begin
        enc_first = {li_lo, 5'd0, 3'b000, bus.in_rd, OP_ADDI};
      end else if (li_lo == 12'd0) begin
        enc_first = {li_hi, bus.in_rd, OP_LUI};
      end else begin
        enc_first  = {li_hi, bus.in_rd, OP_LUI};
        enc_second = {li_lo, bus.in_rd, 3'b000, bus.in_rd, OP_ADDI};
        enc_last   = 1'b0;
      end
    end else begin
      case (bus.in_fmt)
        5'b10000: begin
          enc_first = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
          enc_err   = ~imm_i_ok;
        end
        5'b01000: begin
          enc_first = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                       bus.in_imm[4:0], bus.in_opcode};
          enc_err   = ~imm_i_ok;
        end
        5'b00100: begin
          enc_first = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                       bus.in_imm[4:1], bus.in_imm[11], bus.in_opcode};
          enc_err   = ~imm_b_ok;
        end
        5'b00010: begin
          enc_first = {bus.in_imm[31:12], bus.in_rd, bus.in_opcode};
          enc_err   = ~imm_u_ok;
        end
        5'b00001: begin
          enc_first = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11], bus.in_imm[19:12],
                       bus.in_rd, bus.in_opcode};
          enc_err   = ~imm_j_ok;
        end
        default: enc_err = 1'b1;
      endcase
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = EMIT1;
      EMIT1:   if (bus.out_ready) state_nxt = last_q ? IDLE : EMIT2;
      EMIT2:   if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state != IDLE);
  end

  // Beat registers only move on accept or on handing over to beat 2, so they hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q   <= '0;
      second_q <= '0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (accept) begin
      inst_q   <= enc_first;
      second_q <= enc_second;
      last_q   <= enc_last;
      err_q    <= enc_err;
    end else if (state == EMIT1 && consume && !last_q) begin
      inst_q <= second_q;
      last_q <= 1'b1;
      err_q  <= 1'b0;
    end
  end

  assign bus.out_inst = inst_q;
  assign bus.out_last = last_q;
  assign bus.out_err  = err_q;

endmodule

// File: doc/ysyx_24070016_idu_immenc.md
# ysyx_24070016_idu_immenc

- Instruction encoder, the inverse of the IDU immediate generator.
- Accepts a field-level instruction description (format, opcode, funct3, register indices, 32-bit immediate) over a valid/ready handshake and emits the packed 32-bit RV32I instruction word.
- Optionally expands a load-immediate into a LUI/ADDI pair.
- Used by the debug instruction injector and the self-test program generator that feed the IFU.

## Interface

Parameters:
- None. Widths are fixed by RV32I.

Ports:
- `clk`  in  1  — system clock; one clock domain, all logic on rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `in_valid`  in  1  — command valid.
- `in_ready`  out  1  — command accepted when `in_valid & in_ready` at a rising edge.
- `in_fmt`  in  5  — one-hot format select: [4]=I, [3]=S, [2]=B, [1]=U, [0]=J (same encoding as the immgen `num_type`).
- `in_li`  in  1  — load-immediate expansion; when 1, `in_fmt`, `in_opcode`, `in_funct3`, `in_rs1` and `in_rs2` are ignored.
- `in_opcode`  in  7  — inst[6:0].
- `in_funct3`  in  3  — inst[14:12] (I/S/B only).
- `in_rd`  in  5  — inst[11:7] (I/U/J, LI).
- `in_rs1`  in  5  — inst[19:15] (I/S/B).
- `in_rs2`  in  5  — inst[24:20] (S/B).
- `in_imm`  in  32  — immediate value, sign-extended semantics.
- `out_valid`  out  1  — instruction beat valid.
- `out_ready`  in  1  — beat consumed when `out_valid & out_ready`.
- `out_inst`  out  32  — packed instruction.
- `out_last`  out  1  — final beat of the current command.
- `out_err`  out  1  — command illegal or immediate unrepresentable.

## Operation

FSM states: IDLE, EMIT1, EMIT2.
- `in_ready = (state == IDLE)`.
- On accept: latch all fields, compute the first beat into the output registers, go to EMIT1.

Single-instruction packing (`in_li = 0`):
- Unused fields are zero.
- I: inst[31:20] = imm[11:0].
- S: inst[31:25] = imm[11:5]; inst[11:7] = imm[4:0].
- B: inst[31] = imm[12]; [30:25] = imm[10:5]; [11:8] = imm[4:1]; [7] = imm[11].
- U: inst[31:12] = imm[31:12].
- J: inst[31] = imm[20]; [30:21] = imm[10:1]; [20] = imm[11]; [19:12] = imm[19:12].

Range checks set `out_err` but still emit the truncated encoding:
- I/S: imm[31:11] not all equal.
- B: imm[31:12] not all equal, or imm[0] = 1.
- J: imm[31:20] not all equal, or imm[0] = 1.
- U: imm[11:0] != 0.

Illegal format:
- `in_fmt` not exactly one-hot → `out_inst = 0`, `out_err = 1`, single beat.

LI expansion:
- lo = imm[11:0]; hi = imm[31:12] + imm[11], computed modulo 2^20.
- hi == 0 → single ADDI rd, x0, lo (opcode 0010011, funct3 000).
- lo == 0 → single LUI rd, hi (opcode 0110111).
- Otherwise → beat 1 = LUI rd, hi with `out_last = 0`; beat 2 = ADDI rd, rd, lo with `out_last = 1`.
- LI never sets `out_err`.

Transitions:
- EMIT1, beat consumed:
  - if `out_last`: → IDLE, `out_valid` drops.
  - else: load beat 2, → EMIT2.
- EMIT2, beat consumed → IDLE.
- While `out_valid & !out_ready`: `out_inst`, `out_last` and `out_err` hold stable.

## Timing

- Reset values: state = IDLE, `out_valid = 0`, `out_inst = 0`, `out_last = 0`, `out_err = 0`.
  - `in_ready = 1` while in reset and from the first cycle after reset.
  - Reset takes effect immediately (asynchronous) from any state and discards any in-flight command, including a half-emitted LI pair.
- Latency: command accepted at edge N → `out_valid = 1` after edge N. With `out_ready` held high, beat 2 is valid after edge N+1.
- Throughput: one command per 2 cycles (single beat), or per 3 cycles (LI pair), with `out_ready` held high. No new command is accepted in the cycle the last beat is consumed.
- Outputs are registered; there is no combinational path from `in_*` to `out_*`.
- `in_ready` depends only on state; it does not depend on `out_ready`.

## Test plan

1. I-type: fmt = 10000, opcode = 0x13, funct3 = 0, rd = 5, rs1 = 6, imm = 0xFFFFFFFF → `out_inst = 0xFFF30293`, `out_last = 1`, `out_err = 0`, valid one cycle after accept.
2. B-type: fmt = 00100, opcode = 0x63, rs1 = 1, rs2 = 2, imm = 8 → `0x00208463`.
   - Same command with imm = 3 → `out_err = 1`.
   - fmt = 00110 → `out_inst = 0`, `out_err = 1`.
3. LI rd = 10, imm = 0x12345FFF → beat 1 `0x12346537` with `last = 0`; beat 2 `0xFFF50513` with `last = 1`. `in_ready` stays 0 until after beat 2 is consumed.
4. LI single-beat and rounding cases:
   - LI rd = 1, imm = 0x800 → `0x000010B7`, then `0x80008093`.
   - LI rd = 1, imm = 5 → single `0x00500093` with `last = 1`.
   - LI rd = 1, imm = 0x1000 → single `0x000010B7` with `last = 1`.
5. Backpressure: hold `out_ready = 0` for 3 cycles during LI beat 1 → `out_inst`, `out_last` and `out_valid` stay stable and `in_ready = 0`. Release → beat 2 appears on the next cycle.
6. Reset mid-LI: assert `rst_n = 0` while in EMIT1 → `out_valid = 0` and `out_inst = 0` asynchronously. After release, `in_ready = 1` and a new I-type command encodes correctly.
